adf4030_trig_scheduler: RTL and testbench

ADF4030_TRIG_SCHEDULER -- requirements
Module: adf4030_trig_scheduler

---
 rtl/adf4030_pkg.sv | 38 +++
 rtl/adf4030_trig_channel.sv | 63 ++++++
 rtl/adf4030_trig_scheduler.sv | 107 ++++++++++
 tb/tb_adf4030_trig_scheduler.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/adf4030_pkg.sv
// Shared definitions for the ADF4030 trigger scheduler.
//   fsm_state_t        top-level sequencer states
//   TS_*               3-bit per-channel debug state codes, identical to the
//                      per-channel state field of the ADF4030 register map
//   MAX_CHANNELS       upper bound on CHANNEL_COUNT
//   encode_trig_state  maps sequencer state + channel status to a TS_* code
package adf4030_pkg;

  localparam int MAX_CHANNELS = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_COUNT = 2'd2,
    ST_DONE  = 2'd3
  } fsm_state_t;

  localparam logic [2:0] TS_IDLE     = 3'd0;
  localparam logic [2:0] TS_ARMED    = 3'd1;
  localparam logic [2:0] TS_WAIT     = 3'd2;
  localparam logic [2:0] TS_FIRED    = 3'd3;
  localparam logic [2:0] TS_DISABLED = 3'd4;

  function automatic logic [2:0] encode_trig_state(input fsm_state_t st,
                                                   input logic en,
                                                   input logic fired);
    logic [2:0] code;
    code = TS_IDLE;
    if (st != ST_IDLE) begin
      if (!en)                 code = TS_DISABLED;
      else if (st == ST_ARMED) code = TS_ARMED;
      else if (fired)          code = TS_FIRED;
      else                     code = TS_WAIT;
    end
    return code;
  endfunction

endpackage

// File: rtl/adf4030_trig_channel.sv
// One trigger channel: holds the snapshot of its enable and phase, compares
// the shared phase counter against the snapshot phase, fires a single
// registered pulse and reports its debug state.
//   clk, rstn     clock, asynchronous active-low reset
//   load          snapshot strobe (request accepted in IDLE)
//   en_in         live enable, captured on load
//   phase_in      live phase offset, captured on load
//   state         current sequencer state
//   next_state    sequencer state after this edge (keeps trig_state aligned)
//   count         shared phase counter
//   snap_en       captured enable
//   fired         channel has fired in the current sequence
//   trig_out      one-cycle trigger pulse (registered)
//   trig_state    3-bit debug state (registered)
module adf4030_trig_channel
  import adf4030_pkg::*;
#(
  parameter int PHASE_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   load,
  input  logic                   en_in,
  input  logic [PHASE_WIDTH-1:0] phase_in,
  input  fsm_state_t             state,
  input  fsm_state_t             next_state,
  input  logic [PHASE_WIDTH-1:0] count,
  output logic                   snap_en,
  output logic                   fired,
  output logic                   trig_out,
  output logic [2:0]             trig_state
);

  logic [PHASE_WIDTH-1:0] snap_phase;
  logic                   fire;
  logic                   en_next;
  logic                   fired_next;

  // count holds the number of cycles elapsed since the cycle after the BSYNC
  // edge, so matching it against the phase lands the pulse at E+1+phase.
  assign fire       = (state == ST_COUNT) && snap_en && !fired && (count == snap_phase);
  assign en_next    = load ? en_in : snap_en;
  assign fired_next = load ? 1'b0 : (fired | fire);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      snap_en    <= 1'b0;
      snap_phase <= '0;
      fired      <= 1'b0;
      trig_out   <= 1'b0;
      trig_state <= TS_IDLE;
    end else begin
      if (load) begin
        snap_en    <= en_in;
        snap_phase <= phase_in;
      end
      fired      <= fired_next;
      trig_out   <= fire;
      trig_state <= encode_trig_state(next_state, en_next, fired_next);
    end
  end

endmodule

// File: rtl/adf4030_trig_scheduler.sv
// ADF4030 trigger scheduler: on trig_req, snapshots per-channel enables and
// phase offsets, waits for a BSYNC rising edge, then emits one trigger pulse
// per enabled channel at its phase offset (in clk cycles) from that edge.
//   clk, rstn            clock, asynchronous active-low reset
//   trig_channel_en      per-channel enable
//   trig_channel_phase   per-channel phase offset, channel i at [i*PW +: PW]
//   bsync                reference sync, already in the clk domain
//   trig_req             single-cycle trigger request
//   trig_out             per-channel one-cycle trigger pulse
//   busy                 sequencer not in IDLE
//   overrun              one-cycle pulse when a request is rejected
//   trig_state           per-channel 3-bit debug state, channel i at [3*i +: 3]
module adf4030_trig_scheduler
  import adf4030_pkg::*;
#(
  parameter int CHANNEL_COUNT = 1,
  parameter int PHASE_WIDTH   = 16
) (
  input  logic                               clk,
  input  logic                               rstn,
  input  logic [CHANNEL_COUNT-1:0]           trig_channel_en,
  input  logic [PHASE_WIDTH*CHANNEL_COUNT-1:0] trig_channel_phase,
  input  logic                               bsync,
  input  logic                               trig_req,
  output logic [CHANNEL_COUNT-1:0]           trig_out,
  output logic                               busy,
  output logic                               overrun,
  output logic [3*CHANNEL_COUNT-1:0]         trig_state
);

  if (CHANNEL_COUNT < 1 || CHANNEL_COUNT > MAX_CHANNELS) begin : g_bad_count
    $error("adf4030_trig_scheduler: CHANNEL_COUNT must be 1..8");
  end

  fsm_state_t               state;
  fsm_state_t               next_state;
  logic [PHASE_WIDTH-1:0]   count;
  logic                     bsync_q;
  logic                     bsync_edge;
  logic                     load;
  logic                     all_fired;
  logic [CHANNEL_COUNT-1:0] snap_en;
  logic [CHANNEL_COUNT-1:0] fired;

  // The phase counter sticks at all-ones so a maximal phase still matches
  // exactly once and nothing can fire again on a wrap.
  function automatic logic [PHASE_WIDTH-1:0] sat_inc(input logic [PHASE_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign bsync_edge = bsync & ~bsync_q;
  assign load       = (state == ST_IDLE) && trig_req;
  assign all_fired  = &(fired | ~snap_en);
  assign busy       = (state != ST_IDLE);

  // An all-zero snapshot passes through ARMED without waiting for BSYNC, so
  // an empty request still shows busy for two cycles and fires nothing.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  if (trig_req) next_state = ST_ARMED;
      ST_ARMED: begin
        if (snap_en == '0)   next_state = ST_DONE;
        else if (bsync_edge) next_state = ST_COUNT;
      end
      ST_COUNT: if (all_fired) next_state = ST_DONE;
      ST_DONE:  next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= ST_IDLE;
      bsync_q <= 1'b0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      state   <= next_state;
      bsync_q <= bsync;
      if (state == ST_ARMED && next_state == ST_COUNT) count <= '0;
      else if (state == ST_COUNT)                      count <= sat_inc(count);
      // DONE still counts as busy, so a request on the DONE->IDLE edge is rejected.
      overrun <= trig_req && (state != ST_IDLE);
    end
  end

  for (genvar i = 0; i < CHANNEL_COUNT; i++) begin : g_ch
    adf4030_trig_channel #(
      .PHASE_WIDTH(PHASE_WIDTH)
    ) u_ch (
      .clk        (clk),
      .rstn       (rstn),
      .load       (load),
      .en_in      (trig_channel_en[i]),
      .phase_in   (trig_channel_phase[i*PHASE_WIDTH +: PHASE_WIDTH]),
      .state      (state),
      .next_state (next_state),
      .count      (count),
      .snap_en    (snap_en[i]),
      .fired      (fired[i]),
      .trig_out   (trig_out[i]),
      .trig_state (trig_state[3*i +: 3])
    );
  end

endmodule

// File: tb/tb_adf4030_trig_scheduler.sv
// Directed bench for adf4030_trig_scheduler with four channels. Expected
// trigger pulses and overrun pulses are queued with the cycle they must appear
// in; a negedge monitor compares every cycle against that queue.
module tb_adf4030_trig_scheduler;

  localparam int NCH = 4;
  localparam int PW  = 16;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic [NCH-1:0]  en = '0;
  logic [PW*NCH-1:0] phase = '0;
  logic            bsync = 1'b0;
  logic            trig_req = 1'b0;
  logic [NCH-1:0]  trig_out;
  logic            busy;
  logic            overrun;
  logic [3*NCH-1:0] trig_state;

  adf4030_trig_scheduler #(
    .CHANNEL_COUNT(NCH),
    .PHASE_WIDTH  (PW)
  ) dut (
    .clk               (clk),
    .rstn              (rstn),
    .trig_channel_en   (en),
    .trig_channel_phase(phase),
    .bsync             (bsync),
    .trig_req          (trig_req),
    .trig_out          (trig_out),
    .busy              (busy),
    .overrun           (overrun),
    .trig_state        (trig_state)
  );

  always #5 clk = ~clk;

  // cyc = number of rising edges so far; stable at the falling edge
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int           at;
    logic [NCH-1:0] trig;
    logic         ov;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push(input int at, input logic [NCH-1:0] trig, input logic ov);
    exp_t e;
    e.at = at; e.trig = trig; e.ov = ov;
    sb.push_back(e);
  endtask

  task automatic go(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  function automatic logic [3*NCH-1:0] ts(input logic [2:0] c3, input logic [2:0] c2,
                                          input logic [2:0] c1, input logic [2:0] c0);
    return {c3, c2, c1, c0};
  endfunction

  // Scoreboard monitor: anything not queued for this cycle must be zero.
  always @(negedge clk) begin
    logic [NCH-1:0] et;
    logic           eo;
    et = '0;
    eo = 1'b0;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].at == cyc) begin
        et |= sb[i].trig;
        eo |= sb[i].ov;
        sb.delete(i);
      end
    end
    check("trig_out", 32'(trig_out), 32'(et));
    check("overrun", 32'(overrun), 32'(eo));
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int k, e, f;
    @(negedge clk);
    go(cyc + 2);
    check("reset_busy", 32'(busy), 0);
    check("reset_state", 32'(trig_state), 0);
    rstn = 1'b1;
    go(cyc + 2);

    // Mixed phases, one disabled channel, inputs changed while ARMED,
    // overrun during COUNT, stray BSYNC during COUNT, request on DONE->IDLE.
    k = cyc;
    en = 4'b1011;
    phase = {16'd9, 16'd5, 16'd5, 16'd0};
    trig_req = 1'b1;
    go(k + 1);
    trig_req = 1'b0;
    check("armed_busy", 32'(busy), 1);
    check("armed_state", 32'(trig_state), 32'(ts(3'd1, 3'd4, 3'd1, 3'd1)));
    en = 4'b0100;
    phase = {16'd1, 16'd1, 16'd1, 16'd1};
    bsync = 1'b1;
    e = k + 2;
    push(e + 1, 4'b0001, 1'b0);
    push(e + 6, 4'b0010, 1'b0);
    push(e + 10, 4'b1000, 1'b0);
    go(k + 2);
    bsync = 1'b0;
    go(e + 3);
    check("count_state", 32'(trig_state), 32'(ts(3'd2, 3'd4, 3'd2, 3'd3)));
    trig_req = 1'b1;
    push(e + 4, '0, 1'b1);
    go(e + 4);
    trig_req = 1'b0;
    bsync = 1'b1;
    go(e + 5);
    bsync = 1'b0;
    f = e + 10;
    go(f);
    check("fire_busy", 32'(busy), 1);
    go(f + 1);
    check("done_busy", 32'(busy), 1);
    check("done_state", 32'(trig_state), 32'(ts(3'd3, 3'd4, 3'd3, 3'd3)));
    trig_req = 1'b1;
    push(f + 2, '0, 1'b1);
    go(f + 2);
    trig_req = 1'b0;
    check("idle_busy", 32'(busy), 0);
    check("idle_state", 32'(trig_state), 0);
    go(f + 3);
    check("rejected_busy", 32'(busy), 0);
    go(cyc + 3);

    // Empty enable: two busy cycles, nothing fires, no overrun.
    k = cyc;
    en = '0;
    trig_req = 1'b1;
    go(k + 1);
    trig_req = 1'b0;
    check("empty_busy1", 32'(busy), 1);
    check("empty_state1", 32'(trig_state), 32'(ts(3'd4, 3'd4, 3'd4, 3'd4)));
    go(k + 2);
    check("empty_busy2", 32'(busy), 1);
    go(k + 3);
    check("empty_busy3", 32'(busy), 0);
    go(cyc + 3);

    // Reset in the middle of COUNT aborts the sequence.
    k = cyc;
    en = 4'b0001;
    phase = 64'd20;
    trig_req = 1'b1;
    go(k + 1);
    trig_req = 1'b0;
    bsync = 1'b1;
    e = k + 2;
    go(k + 2);
    bsync = 1'b0;
    go(e + 5);
    check("pre_rst_busy", 32'(busy), 1);
    rstn = 1'b0;
    #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_state", 32'(trig_state), 0);
    check("rst_trig", 32'(trig_out), 0);
    go(e + 8);
    rstn = 1'b1;
    go(cyc + 2);
    bsync = 1'b1;
    go(cyc + 1);
    bsync = 1'b0;
    go(cyc + 5);
    bsync = 1'b1;
    go(cyc + 1);
    bsync = 1'b0;
    go(e + 40);
    check("post_rst_busy", 32'(busy), 0);

    // Maximal phase on one channel.
    k = cyc;
    en = 4'b0010;
    phase = {16'd0, 16'd0, 16'hFFFF, 16'd0};
    trig_req = 1'b1;
    go(k + 1);
    trig_req = 1'b0;
    bsync = 1'b1;
    e = k + 2;
    f = e + 65536;
    push(f, 4'b0010, 1'b0);
    go(k + 2);
    bsync = 1'b0;
    go(f - 1);
    check("max_wait_busy", 32'(busy), 1);
    check("max_wait_state", 32'(trig_state), 32'(ts(3'd4, 3'd4, 3'd2, 3'd4)));
    go(f + 1);
    check("max_done_busy", 32'(busy), 1);
    go(f + 2);
    check("max_idle_busy", 32'(busy), 0);
    go(f + 6);

    check("sb_empty", 32'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
